// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the SRAM bus controller.
//   state_e      - access sequencer states
//   Def*         - default geometry and timing constants
//   cnt_width()  - width of the shared phase counter for a given timing set
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StStrobe,
        StHold
    } state_e;

    localparam int unsigned DefAddrW     = 11;
    localparam int unsigned DefDataW     = 8;
    localparam int unsigned DefSetupCyc  = 1;
    localparam int unsigned DefStrobeCyc = 2;
    localparam int unsigned DefHoldCyc   = 1;

    // The counter is loaded with (cycles - 1), so clog2 of the largest phase length suffices.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/pio_edge_det.sv
// Rising-edge detector for the PIO enable bit.
//   clk_i   - system clock
//   rst_ni  - asynchronous active-low reset
//   en_i    - level from the enable PIO (same clock domain, no synchroniser)
//   rise_o  - high for the one cycle where en_i is 1 and was 0 on the previous clock
module pio_edge_det (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    output logic rise_o
);

    logic en_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            en_q <= 1'b0;
        end else begin
            en_q <= en_i;
        end
    end

    assign rise_o = en_i & ~en_q;

endmodule

// File: rtl/sram_bus_ctrl.sv
// Turns a bit-banged PIO request into timed strobes for an asynchronous 2K x 8 SRAM.
//   clk_clk, reset_reset_n         - clock and asynchronous active-low reset
//   pio_address/wdata/cs/en/rnw    - request from the Qsys PIOs; rising pio_en starts an access
//   pio_rdata                      - last read result, held until the next read completes
//   busy, done, overrun            - status: access in progress, completion pulse, sticky error
//   sram_addr/ce_n/oe_n/we_n       - registered chip-level address and strobes
//   sram_dq_out/oe/in              - split data pad, the tristate lives in the top level
module sram_bus_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W     = DefAddrW,
    parameter int unsigned DATA_W     = DefDataW,
    parameter int unsigned SETUP_CYC  = DefSetupCyc,
    parameter int unsigned STROBE_CYC = DefStrobeCyc,
    parameter int unsigned HOLD_CYC   = DefHoldCyc
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [ADDR_W-1:0] pio_address,
    input  logic [DATA_W-1:0] pio_wdata,
    input  logic              pio_cs,
    input  logic              pio_en,
    input  logic              pio_rnw,
    output logic [DATA_W-1:0] pio_rdata,
    output logic              busy,
    output logic              done,
    output logic              overrun,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic [DATA_W-1:0] sram_dq_out,
    output logic              sram_dq_oe,
    input  logic [DATA_W-1:0] sram_dq_in
);

    localparam int unsigned CntW = cnt_width(SETUP_CYC, STROBE_CYC, HOLD_CYC);
    localparam logic [CntW-1:0] SetupLoad  = CntW'(SETUP_CYC - 1);
    localparam logic [CntW-1:0] StrobeLoad = CntW'(STROBE_CYC - 1);
    localparam logic [CntW-1:0] HoldLoad   = CntW'(HOLD_CYC - 1);

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              rnw_q, rnw_n;
    logic              en_rise, trig, accept, last;
    logic              capture_rd, done_d, overrun_d;
    logic              ce_n_d, oe_n_d, we_n_d, dq_oe_d;

    pio_edge_det u_edge (
        .clk_i  (clk_clk),
        .rst_ni (reset_reset_n),
        .en_i   (pio_en),
        .rise_o (en_rise)
    );

    assign trig = en_rise & pio_cs;
    assign busy = (state_q != StIdle);
    assign last = (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (trig) begin
                    accept  = 1'b1;
                    state_d = StSetup;
                    cnt_d   = SetupLoad;
                end
            end
            StSetup: begin
                if (last) begin
                    state_d = StStrobe;
                    cnt_d   = StrobeLoad;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StStrobe: begin
                if (last) begin
                    state_d = StHold;
                    cnt_d   = HoldLoad;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StHold: begin
                if (last) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Strobes are decoded from the next state so the pins change exactly on the state edge
    // and come straight out of flops.
    always_comb begin
        rnw_n      = accept ? pio_rnw : rnw_q;
        ce_n_d     = (state_d == StIdle);
        oe_n_d     = ~(rnw_n & ((state_d == StSetup) | (state_d == StStrobe)));
        we_n_d     = ~(~rnw_n & (state_d == StStrobe));
        dq_oe_d    = ~rnw_n & (state_d != StIdle);
        capture_rd = (state_q == StStrobe) & last & rnw_q;
        done_d     = (state_q == StHold) & last;
        overrun_d  = overrun;
        if (!pio_cs) begin
            overrun_d = 1'b0;
        end else if (trig && busy) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            rnw_q       <= 1'b0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            pio_rdata   <= '0;
            done        <= 1'b0;
            overrun     <= 1'b0;
            sram_ce_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
            sram_we_n   <= 1'b1;
            sram_dq_oe  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rnw_q      <= rnw_n;
            done       <= done_d;
            overrun    <= overrun_d;
            sram_ce_n  <= ce_n_d;
            sram_oe_n  <= oe_n_d;
            sram_we_n  <= we_n_d;
            sram_dq_oe <= dq_oe_d;
            if (accept) begin
                sram_addr   <= pio_address;
                sram_dq_out <= pio_wdata;
            end
            if (capture_rd) begin
                pio_rdata <= sram_dq_in;
            end
        end
    end

endmodule

// File: tb/tb_sram_bus_ctrl.sv
// Self-checking bench: a default-timing DUT and a SETUP=2/STROBE=3/HOLD=2 DUT share one
// PIO stimulus stream and are each compared every cycle against a phase-count model.
module tb_sram_bus_ctrl;

    localparam int AW = 11;
    localparam int DW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          pio_en, pio_cs, pio_rnw;
    logic [AW-1:0] pio_address;
    logic [DW-1:0] pio_wdata;

    logic [1:0][DW-1:0] rdata, dq_out, dq_in;
    logic [1:0][AW-1:0] addr;
    logic [1:0]         busy, done, overrun, ce_n, oe_n, we_n, dq_oe;

    // Behavioural SRAMs seen by each DUT, and the model's own view of their contents.
    logic [DW-1:0] mem     [2][2048];
    logic [DW-1:0] ref_mem [2][2048];

    assign dq_in[0] = (!ce_n[0] && !oe_n[0]) ? mem[0][addr[0]] : '0;
    assign dq_in[1] = (!ce_n[1] && !oe_n[1]) ? mem[1][addr[1]] : '0;

    sram_bus_ctrl dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .pio_address   (pio_address),
        .pio_wdata     (pio_wdata),
        .pio_cs        (pio_cs),
        .pio_en        (pio_en),
        .pio_rnw       (pio_rnw),
        .pio_rdata     (rdata[0]),
        .busy          (busy[0]),
        .done          (done[0]),
        .overrun       (overrun[0]),
        .sram_addr     (addr[0]),
        .sram_ce_n     (ce_n[0]),
        .sram_oe_n     (oe_n[0]),
        .sram_we_n     (we_n[0]),
        .sram_dq_out   (dq_out[0]),
        .sram_dq_oe    (dq_oe[0]),
        .sram_dq_in    (dq_in[0])
    );

    sram_bus_ctrl #(
        .SETUP_CYC  (2),
        .STROBE_CYC (3),
        .HOLD_CYC   (2)
    ) dut_sweep (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .pio_address   (pio_address),
        .pio_wdata     (pio_wdata),
        .pio_cs        (pio_cs),
        .pio_en        (pio_en),
        .pio_rnw       (pio_rnw),
        .pio_rdata     (rdata[1]),
        .busy          (busy[1]),
        .done          (done[1]),
        .overrun       (overrun[1]),
        .sram_addr     (addr[1]),
        .sram_ce_n     (ce_n[1]),
        .sram_oe_n     (oe_n[1]),
        .sram_we_n     (we_n[1]),
        .sram_dq_out   (dq_out[1]),
        .sram_dq_oe    (dq_oe[1]),
        .sram_dq_in    (dq_in[1])
    );

    int sc[2]  = '{1, 2};
    int stc[2] = '{2, 3};
    int hc[2]  = '{1, 2};

    // Model: ph = 0 when idle, otherwise 1-based cycle number within the access.
    int            ph      [2];
    bit            m_done  [2];
    bit            m_ovr   [2];
    bit            m_rnw   [2];
    logic [AW-1:0] m_addr  [2];
    logic [DW-1:0] m_wdata [2];
    logic [DW-1:0] m_rdata [2];
    bit            en_prev;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            // An interrupted write leaves that location undefined; adopt whatever the SRAM holds.
            if (ph[d] != 0 && !m_rnw[d]) ref_mem[d][m_addr[d]] = mem[d][m_addr[d]];
            ph[d]      = 0;
            m_done[d]  = 1'b0;
            m_ovr[d]   = 1'b0;
            m_rnw[d]   = 1'b0;
            m_addr[d]  = '0;
            m_wdata[d] = '0;
            m_rdata[d] = '0;
        end
        en_prev = 1'b0;
    endtask

    task automatic model_step(input logic en, input logic cs, input logic rnw,
                              input logic [AW-1:0] a, input logic [DW-1:0] w);
        bit trig;
        trig    = en && !en_prev && cs;
        en_prev = en;
        for (int d = 0; d < 2; d++) begin
            int  t;
            bit  act;
            t   = sc[d] + stc[d] + hc[d];
            act = (ph[d] != 0);
            if (!cs) m_ovr[d] = 1'b0;
            else if (trig && act) m_ovr[d] = 1'b1;
            m_done[d] = (ph[d] == t);
            if (act) begin
                if (m_rnw[d] && ph[d] == sc[d] + stc[d]) m_rdata[d] = ref_mem[d][m_addr[d]];
                ph[d] = (ph[d] == t) ? 0 : ph[d] + 1;
            end else if (trig) begin
                ph[d]      = 1;
                m_rnw[d]   = rnw;
                m_addr[d]  = a;
                m_wdata[d] = w;
                if (!rnw) ref_mem[d][a] = w;
            end
        end
    endtask

    task automatic compare_all();
        for (int d = 0; d < 2; d++) begin
            bit act, rd_win, wr_strobe;
            act       = (ph[d] != 0);
            rd_win    = act && m_rnw[d] && ph[d] <= sc[d] + stc[d];
            wr_strobe = act && !m_rnw[d] && ph[d] > sc[d] && ph[d] <= sc[d] + stc[d];
            check_eq($sformatf("busy%0d", d), 32'(busy[d]), 32'(act));
            check_eq($sformatf("ce_n%0d", d), 32'(ce_n[d]), 32'(!act));
            check_eq($sformatf("oe_n%0d", d), 32'(oe_n[d]), 32'(!rd_win));
            check_eq($sformatf("we_n%0d", d), 32'(we_n[d]), 32'(!wr_strobe));
            check_eq($sformatf("dq_oe%0d", d), 32'(dq_oe[d]), 32'(act && !m_rnw[d]));
            check_eq($sformatf("done%0d", d), 32'(done[d]), 32'(m_done[d]));
            check_eq($sformatf("overrun%0d", d), 32'(overrun[d]), 32'(m_ovr[d]));
            check_eq($sformatf("rdata%0d", d), 32'(rdata[d]), 32'(m_rdata[d]));
            check_eq($sformatf("addr%0d", d), 32'(addr[d]), 32'(m_addr[d]));
            check_eq($sformatf("dq_out%0d", d), 32'(dq_out[d]), 32'(m_wdata[d]));
        end
    endtask

    // One clock: SRAM write side effect, compare, then drive the next request and advance the model.
    task automatic cycle(input logic en, input logic cs, input logic rnw,
                         input logic [AW-1:0] a, input logic [DW-1:0] w);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            if (!we_n[d] && !ce_n[d]) mem[d][addr[d]] = dq_out[d];
        end
        compare_all();
        pio_en      = en;
        pio_cs      = cs;
        pio_rnw     = rnw;
        pio_address = a;
        pio_wdata   = w;
        model_step(en, cs, rnw, a, w);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 1'b0, '0, '0);
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) begin
            mem[0][i]     = 8'(i) ^ 8'hA5;
            mem[1][i]     = 8'(i) ^ 8'h3C;
            ref_mem[0][i] = 8'(i) ^ 8'hA5;
            ref_mem[1][i] = 8'(i) ^ 8'h3C;
            ph[0]         = 0;
            ph[1]         = 0;
        end
        pio_en = 1'b0; pio_cs = 1'b1; pio_rnw = 1'b0; pio_address = '0; pio_wdata = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Write 0x5C to 0x2A5, read it back, then a write that must not disturb pio_rdata.
        cycle(1'b1, 1'b1, 1'b0, 11'h2A5, 8'h5C);
        idle(8);
        cycle(1'b1, 1'b1, 1'b1, 11'h2A5, 8'h00);
        idle(8);
        cycle(1'b1, 1'b1, 1'b0, 11'h000, 8'hE7);
        idle(8);

        // Overrun: second rising edge while busy, then cs low clears the flag.
        cycle(1'b1, 1'b1, 1'b1, 11'h2A5, 8'h00);
        cycle(1'b0, 1'b1, 1'b1, 11'h2A5, 8'h00);
        cycle(1'b1, 1'b1, 1'b0, 11'h123, 8'h99);
        idle(2);
        cycle(1'b0, 1'b0, 1'b0, 11'h000, 8'h00);
        idle(8);

        // Held enable must not retrigger.
        cycle(1'b1, 1'b1, 1'b1, 11'h010, 8'h00);
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b0, 11'h011, 8'h11);
        idle(2);

        // Back-to-back: re-trigger in the default DUT's done cycle.
        cycle(1'b1, 1'b1, 1'b0, 11'h040, 8'h4A);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 11'h000, 8'h00);
        cycle(1'b1, 1'b1, 1'b1, 11'h040, 8'h00);
        idle(10);

        // Reset in the middle of the default DUT's write strobe.
        cycle(1'b1, 1'b1, 1'b0, 11'h155, 8'hC3);
        cycle(1'b0, 1'b1, 1'b0, 11'h000, 8'h00);
        cycle(1'b0, 1'b1, 1'b0, 11'h000, 8'h00);
        check_eq("mid_we_low", 32'(we_n[0]), 32'(0));
        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("rst_we_n%0d", d), 32'(we_n[d]), 32'(1));
            check_eq($sformatf("rst_ce_n%0d", d), 32'(ce_n[d]), 32'(1));
            check_eq($sformatf("rst_dq_oe%0d", d), 32'(dq_oe[d]), 32'(0));
            check_eq($sformatf("rst_busy%0d", d), 32'(busy[d]), 32'(0));
            check_eq($sformatf("rst_rdata%0d", d), 32'(rdata[d]), 32'(0));
        end
        pio_en = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Random traffic over a small address window so reads hit earlier writes.
        for (int i = 0; i < 1500; i++) begin
            cycle(1'($urandom % 2), 1'(($urandom % 8) != 0), 1'($urandom % 2),
                  11'($urandom % 8), 8'($urandom));
        end
        idle(10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
